// File: rtl/ccu_pkg.sv
// Shared definitions for the multi-crossing control unit: state encoding and default phase durations.
package ccu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    ORANGE = 2'd2,
    CLEAR  = 2'd3
  } ccu_state_e;

  localparam int unsigned NUM_XING_DEF = 2;
  localparam int unsigned GREEN_T_DEF  = 4;
  localparam int unsigned ORANGE_T_DEF = 2;
  localparam int unsigned RED_T_DEF    = 4;
  localparam int unsigned TMR_W_DEF    = 8;

endpackage

// File: rtl/ccu_phase_timer.sv
// Down-counting phase timer: loadable, decrement-enabled, saturates at zero.
module ccu_phase_timer
  import ccu_pkg::*;
#(
  parameter int unsigned TMR_W = TMR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/ccu_multi_ctrl.sv
// Multi-crossing control unit: latches requests, grants round-robin, sequences GREEN/ORANGE/CLEAR.
// Optional CCU_EMERGENCY_EN adds an emergency input that forces all-red clearance.
module ccu_multi_ctrl
  import ccu_pkg::*;
#(
  parameter int unsigned NUM_XING = NUM_XING_DEF,
  parameter int unsigned GREEN_T  = GREEN_T_DEF,
  parameter int unsigned ORANGE_T = ORANGE_T_DEF,
  parameter int unsigned RED_T    = RED_T_DEF,
  parameter int unsigned TMR_W    = TMR_W_DEF,
  localparam int unsigned CH_W    = (NUM_XING > 1) ? $clog2(NUM_XING) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_XING-1:0] ped_req,
`ifdef CCU_EMERGENCY_EN
  input  logic                emergency,
`endif
  output logic [NUM_XING-1:0] green_walk,
  output logic [NUM_XING-1:0] orange_walk,
  output logic [NUM_XING-1:0] red_hand,
  output logic                busy,
  output logic [CH_W-1:0]     active_ch
);

  ccu_state_e          state_q, next_state;
  logic [NUM_XING-1:0] pending_q, grant_mask, pending_d;
  logic [CH_W-1:0]     rr_ptr, next_rr, next_ch, pick;
  logic                pick_valid;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;
  logic [NUM_XING-1:0] onehot_d, green_d, orange_d;

  ccu_phase_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero)
  );

  // Round-robin picker: first pending channel at or after rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 0; k < int'(NUM_XING); k++) begin
      if (!pick_valid && pending_q[(int'(rr_ptr) + k) % int'(NUM_XING)]) begin
        pick_valid = 1'b1;
        pick       = CH_W'((int'(rr_ptr) + k) % int'(NUM_XING));
      end
    end
  end

  // Next-state, timer control and grant bookkeeping.
  always_comb begin
    next_state = state_q;
    next_ch    = active_ch;
    next_rr    = rr_ptr;
    grant_mask = '0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          next_state       = GREEN;
          next_ch          = pick;
          next_rr          = (pick == CH_W'(NUM_XING - 1)) ? '0 : pick + CH_W'(1);
          grant_mask[pick] = 1'b1;
          tmr_load         = 1'b1;
          tmr_val          = TMR_W'(GREEN_T - 1);
        end
      end
      GREEN: begin
        if (tmr_zero) begin
          next_state = ORANGE;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(ORANGE_T - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ORANGE: begin
        if (tmr_zero) begin
          next_state = CLEAR;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(RED_T - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CLEAR: begin
        if (tmr_zero) begin
          next_state = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
`ifdef CCU_EMERGENCY_EN
    // Emergency overrides everything; the interrupted grant is dropped, queue untouched.
    if (emergency) begin
      next_state = CLEAR;
      next_ch    = active_ch;
      next_rr    = rr_ptr;
      grant_mask = '0;
      tmr_load   = 1'b1;
      tmr_val    = TMR_W'(RED_T - 1);
      tmr_dec    = 1'b0;
    end
`endif
  end

  // Clearing on the grant edge beats a same-edge request.
  assign pending_d = (pending_q | ped_req) & ~grant_mask;

  // Lamps are registered from the next state so they change with the state.
  assign onehot_d = NUM_XING'(1) << next_ch;
  assign green_d  = (next_state == GREEN)  ? onehot_d : '0;
  assign orange_d = (next_state == ORANGE) ? onehot_d : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      active_ch   <= '0;
      rr_ptr      <= '0;
      pending_q   <= '0;
      green_walk  <= '0;
      orange_walk <= '0;
      red_hand    <= '1;
      busy        <= 1'b0;
    end else begin
      state_q     <= next_state;
      active_ch   <= next_ch;
      rr_ptr      <= next_rr;
      pending_q   <= pending_d;
      green_walk  <= green_d;
      orange_walk <= orange_d;
      red_hand    <= ~(green_d | orange_d);
      busy        <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_ccu_multi_ctrl.sv
// Directed bench for ccu_multi_ctrl (NUM_XING=2, default durations); emergency test under CCU_EMERGENCY_EN.
module tb_ccu_multi_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ped_req;
`ifdef CCU_EMERGENCY_EN
  logic       emergency;
`endif
  logic [1:0] green_walk, orange_walk, red_hand;
  logic       busy;
  logic [0:0] active_ch;

  int errors = 0;
  int checks = 0;

  ccu_multi_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ped_req     (ped_req),
`ifdef CCU_EMERGENCY_EN
    .emergency   (emergency),
`endif
    .green_walk  (green_walk),
    .orange_walk (orange_walk),
    .red_hand    (red_hand),
    .busy        (busy),
    .active_ch   (active_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {green, orange, red}; kind 0=all red, 1=green, 2=orange.
  function automatic logic [5:0] lamp_exp(input int kind, input int ch);
    logic [1:0] oh;
    oh = (ch == 0) ? 2'b01 : 2'b10;
    case (kind)
      1:       lamp_exp = {oh, 2'b00, ~oh};
      2:       lamp_exp = {2'b00, oh, ~oh};
      default: lamp_exp = 6'b000011;
    endcase
  endfunction

  function automatic logic [31:0] lamps();
    lamps = 32'({green_walk, orange_walk, red_hand});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    ped_req = 2'b00;
`ifdef CCU_EMERGENCY_EN
    emergency = 1'b0;
`endif
    step();
    step();
    reset = 1'b1;
  endtask

  // From IDLE with ch pending and winning: walk the 11 edges through one full grant back to IDLE.
  task automatic serve(input string tag, input int ch, input logic [1:0] hold,
                       input int pulse_at, input logic [1:0] pulse_val);
    for (int s = 0; s < 11; s++) begin
      ped_req = hold | ((s == pulse_at) ? pulse_val : 2'b00);
      step();
      if (s == 0) chk({tag, "_ch"}, 32'(active_ch), 32'(ch));
      if (s < 4)       chk({tag, "_green"},  lamps(), 32'(lamp_exp(1, ch)));
      else if (s < 6)  chk({tag, "_orange"}, lamps(), 32'(lamp_exp(2, ch)));
      else             chk({tag, "_red"},    lamps(), 32'(lamp_exp(0, ch)));
      chk({tag, "_busy"}, 32'(busy), (s < 10) ? 32'd1 : 32'd0);
    end
    ped_req = hold;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_lamps", lamps(), 32'(lamp_exp(0, 0)));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ch", 32'(active_ch), 32'd0);

    // Single request, default durations
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    chk("t2_e0_lamps", lamps(), 32'(lamp_exp(0, 0)));
    chk("t2_e0_busy", 32'(busy), 32'd0);
    serve("t2", 0, 2'b00, -1, 2'b00);
    step();
    chk("t2_stay_idle", 32'(busy), 32'd0);

    // Async reset mid-GREEN with ch1 also pending
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    step();
    chk("t1_green", lamps(), 32'(lamp_exp(1, 0)));
    ped_req = 2'b10;
    step();
    ped_req = 2'b00;
    #2 reset = 1'b0;
    #1;
    chk("t1_async_lamps", lamps(), 32'(lamp_exp(0, 0)));
    chk("t1_async_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_pending_cleared", 32'(busy), 32'd0);
    end

    // Simultaneous requests straight out of reset: ch0, then ch1, pointer wraps
    reset   = 1'b0;
    ped_req = 2'b11;
    #2 reset = 1'b1;
    step();
    ped_req = 2'b00;
    serve("t3a", 0, 2'b00, -1, 2'b00);
    serve("t3b", 1, 2'b00, -1, 2'b00);
    step();
    chk("t3_idle", 32'(busy), 32'd0);
    ped_req = 2'b11;
    step();
    ped_req = 2'b00;
    serve("t3wrap", 0, 2'b00, -1, 2'b00);
    serve("t3wrap1", 1, 2'b00, -1, 2'b00);

    // Fairness: ch0 held, ch1 once -> 0,1,0
    do_reset();
    ped_req = 2'b11;
    step();
    serve("t4a", 0, 2'b01, -1, 2'b00);
    serve("t4b", 1, 2'b01, -1, 2'b00);
    serve("t4c", 0, 2'b01, -1, 2'b00);

    // Request on the grant edge is absorbed
    do_reset();
    ped_req = 2'b01;
    step();
    serve("t5abs", 0, 2'b00, 0, 2'b01);
    step();
    chk("t5_absorbed", 32'(busy), 32'd0);
    // Request during own GREEN is kept and served next round
    ped_req = 2'b01;
    step();
    serve("t5g", 0, 2'b00, 2, 2'b01);
    serve("t5again", 0, 2'b00, -1, 2'b00);
    step();
    chk("t5_done", 32'(busy), 32'd0);

`ifdef CCU_EMERGENCY_EN
    // Emergency during GREEN(ch1) with ch0 pending
    do_reset();
    ped_req = 2'b10;
    step();
    ped_req = 2'b00;
    step();
    chk("t6_green1", lamps(), 32'(lamp_exp(1, 1)));
    ped_req = 2'b01;
    step();
    ped_req = 2'b00;
    emergency = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_emg_red", lamps(), 32'(lamp_exp(0, 0)));
      chk("t6_emg_busy", 32'(busy), 32'd1);
    end
    emergency = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_clear_red", lamps(), 32'(lamp_exp(0, 0)));
      chk("t6_clear_busy", 32'(busy), 32'd1);
    end
    step();
    chk("t6_idle", 32'(busy), 32'd0);
    step();
    chk("t6_grant0", lamps(), 32'(lamp_exp(1, 0)));
    chk("t6_ch0", 32'(active_ch), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
